instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 8'h00, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 imem_en  output  1  instruction-memory read request this cycle.
REQ-005 imem_addr  output  8  read address; valid when imem_en=1.
REQ-006 imem_rdata  input  8  read data, returned exactly one cycle after the imem_en cycle.
REQ-007 inst_valid  output  1  inst_data/inst_pc hold a fetched instruction for the decoder.
REQ-008 inst_ready  input  1  decoder accepts the instruction when inst_valid=1 and inst_ready=1.
REQ-009 inst_data  output  8  instruction; op field = bits [7:4].
REQ-010 inst_pc  output  8  address of inst_data.
REQ-011 redirect_valid  input  1  taken branch/jump from execute (ops 1000, 1001, 1100, 1101).
REQ-012 redirect_pc  input  8  new fetch address; sampled when redirect_valid=1.

Function
REQ-013 The block SHALL hold an 8-bit fetch PC that increments by 1 per issued request and wraps from 8'hFF to 8'h00.
REQ-014 The block SHALL hold an in-order instruction buffer of DEPTH entries, each storing {data, pc}; inst_* SHALL present the oldest entry.
REQ-015 imem_en SHALL be asserted only when buffer occupancy plus in-flight requests is less than DEPTH, counting an entry popped this cycle as freed.
REQ-016 Returned imem_rdata SHALL be written into the buffer at the end of the return cycle, tagged with the address issued one cycle earlier.
REQ-017 With continuous inst_ready=1 and no redirect, the block SHALL deliver one instruction per cycle after the initial fill.
REQ-018 With inst_ready=0, inst_data and inst_pc SHALL hold stable while inst_valid=1; no instruction SHALL be dropped or duplicated.
REQ-019 On redirect_valid=1 the block SHALL, in that cycle, suppress imem_en, and at the rising edge set PC to redirect_pc, empty the buffer, and mark any in-flight response as discarded.
REQ-020 The first request after a redirect SHALL be issued in the next cycle at redirect_pc; inst_valid SHALL be 0 for exactly 2 cycles after the redirect edge when the buffer was non-empty.
REQ-021 Redirect SHALL take priority over a simultaneous pop, push, or issue; a handshake in the redirect cycle SHALL still count as accepted.
REQ-022 Back-to-back redirects SHALL each restart fetch; only the last redirect_pc SHALL take effect.

Reset
REQ-023 While rst=1: PC=RESET_PC, buffer empty, in-flight cleared, imem_en=0, inst_valid=0, inst_data=8'h00, inst_pc=8'h00.
REQ-024 imem_en SHALL assert with imem_addr=RESET_PC in the first cycle after rst deasserts; inst_valid SHALL rise in the second cycle after rst deasserts.
REQ-025 Reset asserted mid-operation SHALL discard the in-flight response and all buffered entries immediately.

Configuration
REQ-026 Macro IFETCH_SKID_EN: when defined, DEPTH=2, giving full throughput across single-cycle stalls; when undefined, DEPTH=1, and a one-cycle bubble follows every stall or pop.

Structure
REQ-027 Shared package SHALL hold: the 4-bit opcode constants (MOVE 0000 through LI 1111), the instruction width (8), and the PC width (8).
REQ-028 The instruction buffer SHALL be a sub-module named ifetch_buf, a synchronous FIFO parameterised by DEPTH, with a flush input.

Verification
REQ-029 Release reset with RESET_PC=8'h10 and inst_ready=1, memory at addr returns addr^8'hA5 -> inst_pc sequence 10, 11, 12 on consecutive cycles starting 2 cycles after release, with inst_data=B5, B4, B7.
REQ-030 Hold inst_ready=0 for 5 cycles mid-stream -> inst_data/inst_pc stable; imem_en deasserts once occupancy plus in-flight reaches DEPTH; no gap in the inst_pc sequence after release.
REQ-031 Redirect to 8'h40 while one entry is buffered and one request is in flight -> stale data is never presented; the next valid instruction has inst_pc=40 and appears 2 cycles after the redirect edge.
REQ-032 Start at PC 8'hFE with continuous ready -> inst_pc sequence FE, FF, 00, 01.
REQ-033 Assert rst for 1 cycle while the buffer is full and a request is in flight -> all outputs return to reset values and fetch restarts at RESET_PC.
REQ-034 Redirect in the same cycle as a handshake at inst_pc=20 -> that instruction is counted as accepted exactly once, and inst_pc=20 is not presented again.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared widths, opcode map and buffer entry type for the instruction fetch unit.
// IFETCH_SKID_EN selects a two-entry buffer; the default build uses a single entry.
package instr_fetch_pkg;

    localparam int INST_W = 8;
    localparam int PC_W   = 8;

`ifdef IFETCH_SKID_EN
    localparam int IFETCH_DEPTH = 2;
`else
    localparam int IFETCH_DEPTH = 1;
`endif

    localparam int IFETCH_CNT_W = $clog2(IFETCH_DEPTH + 1);

    typedef enum logic [3:0] {
        OP_MOVE = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_AND  = 4'b0011,
        OP_OR   = 4'b0100,
        OP_XOR  = 4'b0101,
        OP_SHL  = 4'b0110,
        OP_SHR  = 4'b0111,
        OP_BEQ  = 4'b1000,
        OP_BNE  = 4'b1001,
        OP_LD   = 4'b1010,
        OP_ST   = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_JAL  = 4'b1101,
        OP_CMP  = 4'b1110,
        OP_LI   = 4'b1111
    } opcode_t;

    typedef struct packed {
        logic [INST_W-1:0] data;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

    function automatic opcode_t op_of(input logic [INST_W-1:0] inst);
        return opcode_t'(inst[INST_W-1:INST_W-4]);
    endfunction

    // Opcodes that execute may turn into a redirect.
    function automatic logic is_flow_op(input opcode_t op);
        return op inside {OP_BEQ, OP_BNE, OP_JMP, OP_JAL};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundles the memory, decoder and redirect signals of the fetch unit.
// master = fetch unit side, slave = memory/decoder/execute side.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic              imem_en;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [PC_W-1:0]   inst_pc;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;

    modport master (
        output imem_en, imem_addr, inst_valid, inst_data, inst_pc,
        input  imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_en, imem_addr, inst_valid, inst_data, inst_pc,
        output imem_rdata, inst_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/instr_fetch_buf.sv
// ifetch_buf: in-order synchronous FIFO of {data, pc} entries with flush.
// Entry 0 is always the oldest, so the head needs no read pointer.
module ifetch_buf
    import instr_fetch_pkg::*;
#(
    parameter int  DEPTH = 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_entry,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem   [DEPTH];
    fetch_entry_t     mem_n [DEPTH];
    logic [CNT_W-1:0] count_n;
    logic [CNT_W-1:0] wr_idx;
    logic             pop_ok;

    always_comb begin
        pop_ok = pop && (count != '0);
        wr_idx = count - CNT_W'(pop_ok);
        for (int i = 0; i < DEPTH; i++) begin
            mem_n[i] = mem[i];
        end
        if (pop_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                mem_n[i] = mem[i + 1];
            end
        end
        // The write slot accounts for the shift caused by a same-cycle pop.
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == wr_idx) begin
                    mem_n[i] = push_entry;
                end
            end
        end
        count_n = count - CNT_W'(pop_ok) + CNT_W'(push);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            count <= '0;
        end else begin
            count <= count_n;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= mem_n[i];
            end
        end
    end

    assign head = mem[0];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues one-cycle-latency memory reads and queues results for decode.
// Buffer depth comes from IFETCH_SKID_EN (2 entries when defined, 1 otherwise).
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);

    localparam int OCC_W = IFETCH_CNT_W + 1;

    logic [PC_W-1:0]         pc;
    logic [PC_W-1:0]         inflight_pc;
    logic                    inflight;
    logic [IFETCH_CNT_W-1:0] count;
    logic [OCC_W-1:0]        occ;
    fetch_entry_t            head;
    fetch_entry_t            push_entry;
    logic                    valid;
    logic                    pop;
    logic                    push;
    logic                    issue;
    logic                    flush;

    always_comb begin
        valid      = (count != '0);
        pop        = valid && bus.inst_ready;
        flush      = bus.redirect_valid;
        // An entry leaving this cycle frees its slot for a new request.
        occ        = {1'b0, count} + OCC_W'(inflight) - OCC_W'(pop);
        issue      = !rst && !flush && (occ < OCC_W'(IFETCH_DEPTH));
        push       = inflight && !flush;
        push_entry = '{data: bus.imem_rdata, pc: inflight_pc};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (flush) begin
            // Dropping the in-flight flag discards next cycle's response.
            pc       <= bus.redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + PC_W'(1);
                inflight_pc <= pc;
            end
        end
    end

    ifetch_buf #(
        .DEPTH (IFETCH_DEPTH)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (count)
    );

    assign bus.imem_en    = issue;
    assign bus.imem_addr  = pc;
    assign bus.inst_valid = valid;
    assign bus.inst_data  = head.data;
    assign bus.inst_pc    = head.pc;

endmodule
